// File: rtl/sad_vfrac_block.sv
// Streaming vertical sub-pel SAD engine: 3-row sliding window, five vertical candidates
// (full, +-1/2, +-1/4 pel) accumulated over a block, then reported with the best candidate.
module sad_vfrac_block #(
  parameter int PIX_W = 8,
  parameter int N_PIX = 8,
  parameter int BLK_H = 8,
  parameter int SAD_W = PIX_W + $clog2(N_PIX * BLK_H)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     in_sof,
  input  logic [N_PIX*PIX_W-1:0]   cur_row,
  input  logic [N_PIX*PIX_W-1:0]   org_row,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [5*SAD_W-1:0]       sad,
  output logic [2:0]               best_idx,
  output logic [SAD_W-1:0]         best_sad
);

  localparam int CNT_W = $clog2(BLK_H + 3);
  localparam int EXT_W = PIX_W + 2;
  localparam logic [EXT_W-1:0] ONE = EXT_W'(1);
  localparam logic [EXT_W-1:0] TWO = EXT_W'(2);

  typedef enum logic [2:0] {IDLE, FILL, ACC, DRAIN, OUT} state_t;

  state_t                  r_state, w_state_next;
  logic [CNT_W-1:0]        r_beat;
  logic [N_PIX*PIX_W-1:0]  r_prev1, r_prev2;
  logic [SAD_W-1:0]        r_rs [5];
  logic                    r_rs_valid, r_rs_last;
  logic [SAD_W-1:0]        r_acc [5];
  logic                    r_acc_last;
  logic                    r_out_valid;
  logic [5*SAD_W-1:0]      r_sad;
  logic [2:0]              r_best_idx;
  logic [SAD_W-1:0]        r_best_sad;

  logic                    w_accept, w_sof_acc, w_acc_beat, w_last, w_hs;
  logic [N_PIX*5*EXT_W-1:0] w_diff;
  logic [SAD_W-1:0]        w_rs [5];
  logic [2:0]              w_best_idx;
  logic [SAD_W-1:0]        w_best_sad;

  assign in_ready   = (r_state == IDLE) || (r_state == FILL) || (r_state == ACC);
  assign w_accept   = in_valid && in_ready;
  assign w_sof_acc  = w_accept && in_sof;
  assign w_acc_beat = w_accept && !in_sof && (r_state == ACC);
  assign w_last     = (r_beat == CNT_W'(BLK_H + 1));
  assign w_hs       = (r_state == OUT) && out_ready;

  assign out_valid = r_out_valid;
  assign sad       = r_sad;
  assign best_idx  = r_best_idx;
  assign best_sad  = r_best_sad;

  // Window: U = two beats ago, M = previous beat, L = the row arriving now.
  genvar gi, gk;
  generate
    for (gi = 0; gi < N_PIX; gi++) begin : g_pix
      logic [EXT_W-1:0]   w_u, w_m, w_l, w_o;
      logic [EXT_W-1:0]   w_cand [5];
      assign w_u = {2'b00, r_prev2[gi*PIX_W +: PIX_W]};
      assign w_m = {2'b00, r_prev1[gi*PIX_W +: PIX_W]};
      assign w_l = {2'b00, cur_row[gi*PIX_W +: PIX_W]};
      assign w_o = {2'b00, org_row[gi*PIX_W +: PIX_W]};
      assign w_cand[0] = w_m;
      assign w_cand[1] = (w_u + w_m + ONE) >> 1;
      assign w_cand[2] = (w_m + w_l + ONE) >> 1;
      assign w_cand[3] = (w_u + w_m + (w_m << 1) + TWO) >> 2;
      assign w_cand[4] = (w_m + (w_m << 1) + w_l + TWO) >> 2;
      for (gk = 0; gk < 5; gk++) begin : g_cand
        assign w_diff[(gi*5 + gk)*EXT_W +: EXT_W] =
          (w_cand[gk] >= w_o) ? (w_cand[gk] - w_o) : (w_o - w_cand[gk]);
      end
    end
  endgenerate

  always_comb begin
    for (int k = 0; k < 5; k++) begin
      w_rs[k] = '0;
      for (int p = 0; p < N_PIX; p++) begin
        w_rs[k] = w_rs[k] + SAD_W'(w_diff[(p*5 + k)*EXT_W +: EXT_W]);
      end
    end
  end

  // Strict less-than keeps the lowest index on ties.
  always_comb begin
    w_best_idx = 3'd0;
    w_best_sad = r_acc[0];
    for (int k = 1; k < 5; k++) begin
      if (r_acc[k] < w_best_sad) begin
        w_best_sad = r_acc[k];
        w_best_idx = 3'(k);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      IDLE:  if (w_sof_acc) w_state_next = FILL;
      FILL:  if (w_accept) w_state_next = in_sof ? FILL : ACC;
      ACC: begin
        if (w_sof_acc)                w_state_next = FILL;
        else if (w_accept && w_last)  w_state_next = DRAIN;
      end
      DRAIN: if (r_acc_last) w_state_next = OUT;
      OUT:   if (out_ready) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_beat      <= '0;
      r_prev1     <= '0;
      r_prev2     <= '0;
      r_rs_valid  <= 1'b0;
      r_rs_last   <= 1'b0;
      r_acc_last  <= 1'b0;
      r_out_valid <= 1'b0;
      r_sad       <= '0;
      r_best_idx  <= '0;
      r_best_sad  <= '0;
      for (int k = 0; k < 5; k++) begin
        r_rs[k]  <= '0;
        r_acc[k] <= '0;
      end
    end else begin
      if (w_sof_acc)                         r_beat <= CNT_W'(1);
      else if (w_acc_beat && w_last)         r_beat <= '0;
      else if (w_accept && r_state != IDLE)  r_beat <= r_beat + 1'b1;

      if (w_sof_acc || (w_accept && r_state != IDLE)) begin
        r_prev2 <= r_prev1;
        r_prev1 <= cur_row;
      end

      // Stage 1: register the row sums of one window position.
      r_rs_valid <= w_acc_beat;
      r_rs_last  <= w_acc_beat && w_last;
      if (w_acc_beat) begin
        for (int k = 0; k < 5; k++) r_rs[k] <= w_rs[k];
      end

      // Stage 2: accumulate; an abort or a delivered result starts from zero.
      for (int k = 0; k < 5; k++) begin
        if (w_sof_acc || w_hs) r_acc[k] <= '0;
        else if (r_rs_valid)   r_acc[k] <= r_acc[k] + r_rs[k];
      end
      r_acc_last <= r_rs_valid && r_rs_last;

      if (r_acc_last) begin
        r_out_valid <= 1'b1;
        r_best_idx  <= w_best_idx;
        r_best_sad  <= w_best_sad;
        for (int k = 0; k < 5; k++) r_sad[k*SAD_W +: SAD_W] <= r_acc[k];
      end else if (w_hs) begin
        r_out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sad_vfrac_block.sv
// Directed bench for sad_vfrac_block: uniform rows, ramps, saturation, back-pressure,
// mid-block abort and mid-block reset.
module tb_sad_vfrac_block;
  localparam int PIX_W = 8;
  localparam int N_PIX = 8;
  localparam int BLK_H = 8;
  localparam int SAD_W = PIX_W + $clog2(N_PIX * BLK_H);

  logic                   clk = 1'b0;
  logic                   rst_n = 1'b1;
  logic                   in_valid = 1'b0;
  logic                   in_sof = 1'b0;
  logic                   out_ready = 1'b0;
  logic [N_PIX*PIX_W-1:0] cur_row = '0;
  logic [N_PIX*PIX_W-1:0] org_row = '0;
  logic                   in_ready;
  logic                   out_valid;
  logic [5*SAD_W-1:0]     sad;
  logic [2:0]             best_idx;
  logic [SAD_W-1:0]       best_sad;

  int total = 0;
  int bad = 0;
  int e_ramp [5] = '{128, 256, 0, 192, 64};

  sad_vfrac_block #(.PIX_W(PIX_W), .N_PIX(N_PIX), .BLK_H(BLK_H), .SAD_W(SAD_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_sof(in_sof),
    .cur_row(cur_row), .org_row(org_row), .out_valid(out_valid), .out_ready(out_ready),
    .sad(sad), .best_idx(best_idx), .best_sad(best_sad)
  );

  always #5 clk = ~clk;

  task automatic set_rows(input int cv, input int ov);
    logic [PIX_W-1:0] c8, o8;
    c8 = cv[PIX_W-1:0];
    o8 = ov[PIX_W-1:0];
    cur_row = {N_PIX{c8}};
    org_row = {N_PIX{o8}};
  endtask

  task automatic drive_beat(input bit sof, input int cv, input int ov);
    in_valid = 1'b1;
    in_sof = sof;
    set_rows(cv, ov);
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_sof = 1'b0;
  endtask

  // Beat k carries cur line k-1 and org line k-2; line j = base + step*j.
  task automatic feed(input int cb, input int cs, input int ob, input int os,
                      input int k_from, input int k_to);
    for (int k = k_from; k <= k_to; k++)
      drive_beat(k == 0, cb + cs * (k - 1), (k >= 2) ? ob + os * (k - 2) : 0);
  endtask

  task automatic wait_out(output int cyc);
    cyc = 0;
    while (!out_valid && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    if (!out_valid) cyc = -1;
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    @(posedge clk); #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid got=%0b want=0", out_valid); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_in_ready got=%0b want=1", in_ready); end
    total++; if (sad !== '0) begin bad++; $display("FAIL rst_sad got=%h want=0", sad); end
    total++; if (best_idx !== 3'd0) begin bad++; $display("FAIL rst_best_idx got=%0d want=0", best_idx); end
    total++; if (best_sad !== '0) begin bad++; $display("FAIL rst_best_sad got=%0d want=0", best_sad); end
    rst_n = 1'b1;
    @(posedge clk); #1;
    $display("reset: out_valid=%0b in_ready=%0b", out_valid, in_ready);
  endtask

  task automatic test_flat();
    feed(10, 0, 10, 0, 0, BLK_H + 1);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL flat_lat0 got=%0b want=0", out_valid); end
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL flat_drain_ready got=%0b want=0", in_ready); end
    @(posedge clk); #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL flat_lat1 got=%0b want=0", out_valid); end
    @(posedge clk); #1;
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL flat_lat2 got=%0b want=1", out_valid); end
    for (int k = 0; k < 5; k++) begin
      total++;
      if (sad[k*SAD_W +: SAD_W] !== '0) begin
        bad++; $display("FAIL flat_sad%0d got=%0d want=0", k, sad[k*SAD_W +: SAD_W]);
      end
    end
    total++; if (best_idx !== 3'd0) begin bad++; $display("FAIL flat_best_idx got=%0d want=0", best_idx); end
    total++; if (best_sad !== '0) begin bad++; $display("FAIL flat_best_sad got=%0d want=0", best_sad); end
    consume();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL flat_hs_valid got=%0b want=0", out_valid); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL flat_hs_ready got=%0b want=1", in_ready); end
    $display("flat block: best_idx=%0d best_sad=%0d", best_idx, best_sad);
  endtask

  task automatic test_ramp();
    int cyc;
    feed(8, 4, 10, 4, 0, BLK_H + 1);
    wait_out(cyc);
    total++; if (cyc < 0) begin bad++; $display("FAIL ramp_timeout got=none want=out_valid"); end
    for (int k = 0; k < 5; k++) begin
      total++;
      if (sad[k*SAD_W +: SAD_W] !== SAD_W'(e_ramp[k])) begin
        bad++; $display("FAIL ramp_sad%0d got=%0d want=%0d", k, sad[k*SAD_W +: SAD_W], e_ramp[k]);
      end
    end
    total++; if (best_idx !== 3'd2) begin bad++; $display("FAIL ramp_best_idx got=%0d want=2", best_idx); end
    total++; if (best_sad !== '0) begin bad++; $display("FAIL ramp_best_sad got=%0d want=0", best_sad); end
    consume();
    $display("ramp block: best_idx=%0d best_sad=%0d", best_idx, best_sad);
  endtask

  task automatic test_max();
    int cyc;
    feed(255, 0, 0, 0, 0, BLK_H + 1);
    wait_out(cyc);
    total++; if (cyc < 0) begin bad++; $display("FAIL max_timeout got=none want=out_valid"); end
    for (int k = 0; k < 5; k++) begin
      total++;
      if (sad[k*SAD_W +: SAD_W] !== SAD_W'(16320)) begin
        bad++; $display("FAIL max_sad%0d got=%0d want=16320", k, sad[k*SAD_W +: SAD_W]);
      end
    end
    total++; if (best_idx !== 3'd0) begin bad++; $display("FAIL max_best_idx got=%0d want=0", best_idx); end
    total++; if (best_sad !== SAD_W'(16320)) begin bad++; $display("FAIL max_best_sad got=%0d want=16320", best_sad); end
    consume();
    $display("max block: best_idx=%0d best_sad=%0d", best_idx, best_sad);
  endtask

  task automatic test_backpressure();
    int cyc;
    feed(10, 0, 10, 0, 0, BLK_H + 1);
    wait_out(cyc);
    total++; if (cyc < 0) begin bad++; $display("FAIL bp_timeout got=none want=out_valid"); end
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL bp_valid_c%0d got=%0b want=1", c, out_valid); end
      total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_ready_c%0d got=%0b want=0", c, in_ready); end
      total++; if (sad !== '0) begin bad++; $display("FAIL bp_sad_c%0d got=%h want=0", c, sad); end
    end
    consume();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL bp_release got=%0b want=0", out_valid); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_release_ready got=%0b want=1", in_ready); end
    $display("backpressure: held 5 cycles, out_valid=%0b after handshake", out_valid);
  endtask

  task automatic test_abort();
    int cyc;
    feed(255, 0, 0, 0, 0, 4);
    feed(8, 4, 10, 4, 0, BLK_H + 1);
    wait_out(cyc);
    total++; if (cyc < 0) begin bad++; $display("FAIL abort_timeout got=none want=out_valid"); end
    for (int k = 0; k < 5; k++) begin
      total++;
      if (sad[k*SAD_W +: SAD_W] !== SAD_W'(e_ramp[k])) begin
        bad++; $display("FAIL abort_sad%0d got=%0d want=%0d", k, sad[k*SAD_W +: SAD_W], e_ramp[k]);
      end
    end
    total++; if (best_idx !== 3'd2) begin bad++; $display("FAIL abort_best_idx got=%0d want=2", best_idx); end
    consume();
    $display("abort block: best_idx=%0d best_sad=%0d", best_idx, best_sad);
  endtask

  task automatic test_reset_mid();
    int cyc;
    feed(8, 4, 10, 4, 0, 5);
    in_valid = 1'b1;
    set_rows(8 + 4 * 5, 10 + 4 * 4);
    #2 rst_n = 1'b0;
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL mrst_valid got=%0b want=0", out_valid); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL mrst_ready got=%0b want=1", in_ready); end
    total++; if (sad !== '0) begin bad++; $display("FAIL mrst_sad got=%h want=0", sad); end
    total++; if (best_idx !== 3'd0) begin bad++; $display("FAIL mrst_best_idx got=%0d want=0", best_idx); end
    total++; if (best_sad !== '0) begin bad++; $display("FAIL mrst_best_sad got=%0d want=0", best_sad); end
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    drive_beat(1'b0, 200, 0);
    feed(8, 4, 10, 4, 0, BLK_H + 1);
    wait_out(cyc);
    total++; if (cyc < 0) begin bad++; $display("FAIL mrst_timeout got=none want=out_valid"); end
    for (int k = 0; k < 5; k++) begin
      total++;
      if (sad[k*SAD_W +: SAD_W] !== SAD_W'(e_ramp[k])) begin
        bad++; $display("FAIL mrst_sad%0d got=%0d want=%0d", k, sad[k*SAD_W +: SAD_W], e_ramp[k]);
      end
    end
    total++; if (best_idx !== 3'd2) begin bad++; $display("FAIL mrst_best_idx2 got=%0d want=2", best_idx); end
    consume();
    $display("reset mid-block then ramp: best_idx=%0d best_sad=%0d", best_idx, best_sad);
  endtask

  initial begin
    test_reset();
    test_flat();
    test_ramp();
    test_max();
    test_backpressure();
    test_abort();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
